// File: rtl/prefix_carry_pipe.sv
// 8-bit Kogge-Stone carry network split into three stall-able register stages.
// Input is pre-decoded generate/propagate/half-sum; output is sum and carry-out.
module prefix_carry_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] g_in,
  input  logic [7:0] p_in,
  input  logic [7:0] x_in,
  input  logic       cin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] sum,
  output logic       cout
);

  localparam int unsigned W = 8;

  typedef struct packed {
    logic         v;
    logic         c;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] x;
  } stage_t;

  stage_t s1, s2, s3;
  stage_t s1_d, s2_d, s3_d;
  logic [W-1:0] g_fold;
  logic adv;

  // The pipe moves as one unit; it only stalls when a result is waiting downstream.
  assign adv      = !s3.v || out_ready;
  assign in_ready = adv;

  // Fold cin into bit 0, then span-1 combine.
  always_comb begin
    g_fold    = g_in;
    g_fold[0] = g_in[0] | (p_in[0] & cin);
    s1_d      = '0;
    s1_d.v    = in_valid;
    s1_d.c    = cin;
    s1_d.x    = x_in;
    s1_d.g[0] = g_fold[0];
    s1_d.p[0] = p_in[0];
    for (int i = 1; i < int'(W); i++) begin
      s1_d.g[i] = g_fold[i] | (p_in[i] & g_fold[i-1]);
      s1_d.p[i] = p_in[i] & p_in[i-1];
    end
  end

  // Span-2 combine.
  always_comb begin
    s2_d = s1;
    for (int i = 2; i < int'(W); i++) begin
      s2_d.g[i] = s1.g[i] | (s1.p[i] & s1.g[i-2]);
      s2_d.p[i] = s1.p[i] & s1.p[i-2];
    end
  end

  // Span-4 combine; afterwards g[i] is the carry out of bit i.
  always_comb begin
    s3_d = s2;
    for (int i = 4; i < int'(W); i++) begin
      s3_d.g[i] = s2.g[i] | (s2.p[i] & s2.g[i-4]);
      s3_d.p[i] = s2.p[i] & s2.p[i-4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (adv) begin
      s1 <= s1_d;
      s2 <= s2_d;
      s3 <= s3_d;
    end
  end

  assign out_valid = s3.v;
  assign sum       = s3.x ^ {s3.g[W-2:0], s3.c};
  assign cout      = s3.g[W-1];

endmodule

// File: tb/tb_prefix_carry_pipe.sv
// Scoreboard bench for prefix_carry_pipe: driver pushes A+B+cin expectations,
// an independent negedge monitor pops and compares on every output transfer.
module tb_prefix_carry_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] g_in, p_in, x_in;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  bit rand_done;
  logic [7:0] corner [7] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'h55, 8'hAA};
  logic [7:0] ba [5];
  logic [7:0] bb [5];
  logic       bc [5];

  always #5 clk = ~clk;

  prefix_carry_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g_in      (g_in),
    .p_in      (p_in),
    .x_in      (x_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  // Reference: plain 9-bit addition, {cout, sum}.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic c);
    return 9'(a) + 9'(b) + 9'(c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic align;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic v);
    align();
    out_ready = v;
  endtask

  // Present one operand set; called at posedge+1, returns at posedge+1 after the transfer.
  task automatic send(input logic [7:0] g, input logic [7:0] p, input logic [7:0] x,
                      input logic c, input logic [8:0] exp);
    int n;
    in_valid = 1'b1;
    g_in = g;
    p_in = p;
    x_in = x;
    cin  = c;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_ready !== 1'b1 && n < 200);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %b expected 1", in_ready);
    end else begin
      exp_q.push_back(exp);
    end
    align();
    in_valid = 1'b0;
  endtask

  task automatic send_ab(input logic [7:0] a, input logic [7:0] b, input logic c);
    send(a & b, a | b, a ^ b, c, ref_add(a, b, c));
  endtask

  task automatic lat_check(input string name, input logic [7:0] g, input logic [7:0] p,
                           input logic [7:0] x, input logic c, input logic [8:0] exp);
    int n;
    send(g, p, x, c, exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 10);
    check({name, "_latency"}, 32'(n), 32'd3);
    align();
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    align();
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected no output", {cout, sum});
        end else begin
          e = exp_q.pop_front();
          check("result", 32'({cout, sum}), 32'(e));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    g_in = '0;
    p_in = '0;
    x_in = '0;
    cin = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    @(posedge clk);
    align();
    rst = 1'b0;
    out_ready = 1'b1;

    // Directed carry cases; the first transfer lands on the first edge after release.
    lat_check("ripple",     8'h01, 8'hFF, 8'hFE, 1'b0, 9'h100);
    lat_check("no_carry",   8'h00, 8'h7F, 8'h7F, 1'b0, 9'h07F);
    lat_check("cin_only",   8'h00, 8'h00, 8'h00, 1'b1, 9'h001);
    lat_check("cin_ripple", 8'h00, 8'hFF, 8'hFF, 1'b1, 9'h100);

    // Backpressure: freeze with the first result held, then stream out 1/cycle.
    for (int i = 0; i < 5; i++) begin
      ba[i] = 8'($urandom);
      bb[i] = 8'($urandom);
      bc[i] = 1'($urandom_range(0, 1));
    end
    set_ready(1'b0);
    fork
      begin
        for (int i = 0; i < 5; i++) send_ab(ba[i], bb[i], bc[i]);
      end
      begin
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("bp_first_valid", 32'(out_valid), 32'd1);
        repeat (4) begin
          @(negedge clk);
          check("bp_hold",     32'({cout, sum}), 32'(ref_add(ba[0], bb[0], bc[0])));
          check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        align();
        out_ready = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("bp_stream_valid", 32'(out_valid), 32'd1);
        end
      end
    join
    align();
    drain();

    // Random operands with random input gaps and random downstream stalls.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12000; i++) begin
          if ($urandom_range(0, 3) == 0) align();
          send_ab(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          align();
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Corner operand cross product, back-to-back.
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++)
        for (int c = 0; c < 2; c++)
          send_ab(corner[i], corner[j], 1'(c));
    drain();

    // Reset with sets in flight: everything outstanding is discarded.
    set_ready(1'b0);
    for (int i = 0; i < 3; i++) send_ab(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_sum",       32'(sum),       32'd0);
    check("mid_rst_cout",      32'(cout),      32'd0);
    exp_q.delete();
    @(posedge clk);
    align();
    rst = 1'b0;
    out_ready = 1'b1;
    lat_check("post_rst", 8'h0F, 8'hFF, 8'hF0, 1'b1, ref_add(8'hFF, 8'h0F, 1'b1));
    repeat (6) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
